regfile_fib_writer: RTL and testbench

//  Write-side counterpart to the register-file adder top. The adder top reads

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_fib_writer_fib_step.sv | 36 +++
 rtl/regfile_fib_writer.sv | 88 ++++++++
 tb/tb_regfile_fib_writer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file adder and writer blocks:
// default widths and the writer FSM state encoding.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/regfile_fib_writer_fib_step.sv
// Holds the word currently offered on the write port and the word after it;
// a shift advances the pair by one Fibonacci step.
module fib_step #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] seed0,
    input  logic [DATA_W-1:0] seed1,
    output logic [DATA_W-1:0] word
);

    logic [DATA_W-1:0] cur_word;
    logic [DATA_W-1:0] nxt_word;
    logic [DATA_W-1:0] sum;

    // Carry out of the add is dropped: words wrap modulo 2**DATA_W.
    assign sum  = cur_word + nxt_word;
    assign word = cur_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_word <= '0;
            nxt_word <= '0;
        end else if (load) begin
            cur_word <= seed0;
            nxt_word <= seed1;
        end else if (shift) begin
            cur_word <= nxt_word;
            nxt_word <= sum;
        end
    end

endmodule

// File: rtl/regfile_fib_writer.sv
// Fills NREG consecutive register-file words with a Fibonacci sequence
// through a single ready/valid write port.
module regfile_fib_writer
    import regfile_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int NREG      = 32,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] seed0,
    input  logic [DATA_W-1:0] seed1,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] last_word
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    logic [1:0]        state;
    logic [ADDR_W-1:0] count;
    logic [DATA_W-1:0] word;
    logic              load;
    logic              accept;

    assign load   = (state == ST_IDLE) && start;
    // abort wins over a write completing in the same cycle
    assign accept = (state == ST_WRITE) && wr_ready && !abort;

    assign we    = (state == ST_WRITE);
    assign busy  = (state == ST_WRITE);
    assign done  = (state == ST_DONE);
    assign waddr = BASE + count;
    assign wdata = word;

    fib_step #(
        .DATA_W (DATA_W)
    ) u_fib_step (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (accept),
        .seed0 (seed0),
        .seed1 (seed1),
        .word  (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            count     <= '0;
            last_word <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_WRITE;
                        count <= '0;
                    end
                end
                ST_WRITE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (wr_ready) begin
                        last_word <= word;
                        if (count == LAST_IDX) begin
                            state <= ST_DONE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_fib_writer.sv
// Scoreboard bench: stimulus queues the expected writes from a Fibonacci
// model, a negedge monitor pops and compares every accepted write.
module tb_regfile_fib_writer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [DATA_W-1:0] seed0 = '0;
    logic [DATA_W-1:0] seed1 = '0;
    logic              wr_ready = 1'b1;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] last_word;

    regfile_fib_writer #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .NREG      (NREG),
        .BASE_ADDR (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .seed0     (seed0),
        .seed1     (seed1),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .wr_ready  (wr_ready),
        .busy      (busy),
        .done      (done),
        .last_word (last_word)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  wr_cnt = 0;
    int  done_cnt = 0;
    int  last_done_cyc = -1;
    bit  bp_mode = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin
        #1;
        wr_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [DATA_W-1:0] fib_word(input logic [DATA_W-1:0] s0,
                                                   input logic [DATA_W-1:0] s1,
                                                   input int idx);
        logic [DATA_W-1:0] words[$];
        words.push_back(s0);
        words.push_back(s1);
        for (int i = 2; i <= idx; i++) words.push_back(words[i-1] + words[i-2]);
        return words[idx];
    endfunction

    task automatic push_seq(input logic [DATA_W-1:0] s0, input logic [DATA_W-1:0] s1, input int n);
        wr_t w;
        for (int i = 0; i < n; i++) begin
            w.addr = ADDR_W'(i);
            w.data = fib_word(s0, s1, i);
            exp_q.push_back(w);
        end
    endtask

    // Monitor: compares each accepted write and checks stall stability.
    logic prev_stall = 1'b0;
    logic prev_abort = 1'b0;
    wr_t  prev_w;
    always @(negedge clk) begin
        wr_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !prev_abort) begin
                check("stall_we", 64'(we), 64'd1);
                check("stall_addr", 64'(waddr), 64'(prev_w.addr));
                check("stall_data", 64'(wdata), 64'(prev_w.data));
            end
            if (done) begin
                check("done_we_overlap", 64'(we), 64'd0);
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (we && wr_ready && !abort) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual addr=%0h data=%0h required none", waddr, wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", 64'(waddr), 64'(e.addr));
                    check("write_data", 64'(wdata), 64'(e.data));
                end
                wr_cnt++;
            end
            prev_stall = we && !wr_ready;
            prev_abort = abort;
            prev_w.addr = waddr;
            prev_w.data = wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [DATA_W-1:0] s0, input logic [DATA_W-1:0] s1, output int k);
        seed0 = s0;
        seed1 = s1;
        start = 1'b1;
        k = cyc + 1;
        tick();
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) tick();
        check("done_seen", 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic wait_writes(input int target, input int budget);
        for (int i = 0; i < budget && wr_cnt < target; i++) tick();
        check("writes_reached", 64'(wr_cnt), 64'(target));
    endtask

    task automatic check_idle_after(input string name);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int base;
        int d0;
        logic [DATA_W-1:0] s0, s1;

        // Reset state
        tick();
        tick();
        check("rst_we", 64'(we), 64'd0);
        check("rst_waddr", 64'(waddr), 64'd0);
        check("rst_wdata", 64'(wdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_last_word", 64'(last_word), 64'd0);
        rst_n = 1'b1;
        tick();

        // 1: plain Fibonacci, no backpressure
        push_seq(32'd0, 32'd1, NREG);
        do_start(32'd0, 32'd1, k);
        wait_done(100);
        check("t1_done_cycle", 64'(last_done_cyc), 64'(k + NREG));
        check("t1_last_word", 64'(last_word), 64'd1346269);
        check_idle_after("t1");
        tick();

        // 2: random backpressure
        bp_mode = 1'b1;
        push_seq(32'd0, 32'd1, NREG);
        do_start(32'd0, 32'd1, k);
        wait_done(400);
        check("t2_last_word", 64'(last_word), 64'd1346269);
        check_idle_after("t2");
        bp_mode = 1'b0;
        tick();

        // 3: wrap-around of the add
        push_seq(32'hFFFF_FFFF, 32'd1, NREG);
        do_start(32'hFFFF_FFFF, 32'd1, k);
        wait_done(100);
        check("t3_last_word", 64'(last_word), 64'(fib_word(32'hFFFF_FFFF, 32'd1, NREG - 1)));
        check_idle_after("t3");
        tick();

        // 4: start re-pulsed mid-sequence with different seeds
        push_seq(32'd0, 32'd1, NREG);
        do_start(32'd0, 32'd1, k);
        tick();
        tick();
        seed0 = $urandom;
        seed1 = $urandom;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(100);
        check("t4_done_cycle", 64'(last_done_cyc), 64'(k + NREG));
        check_idle_after("t4");
        tick();

        // Randomized seeds and backpressure
        for (int r = 0; r < 3; r++) begin
            s0 = $urandom;
            s1 = $urandom;
            bp_mode = 1'($urandom_range(0, 1));
            push_seq(s0, s1, NREG);
            do_start(s0, s1, k);
            wait_done(400);
            check("rand_last_word", 64'(last_word), 64'(fib_word(s0, s1, NREG - 1)));
            check_idle_after("rand");
            bp_mode = 1'b0;
            tick();
        end

        // 5: abort with write 5 pending
        s0 = $urandom;
        s1 = $urandom;
        base = wr_cnt;
        d0 = done_cnt;
        push_seq(s0, s1, 5);
        do_start(s0, s1, k);
        wait_writes(base + 5, 100);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_we_dropped", 64'(we), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 4; i++) tick();
        check("t5_no_done", 64'(done_cnt - d0), 64'd0);
        check("t5_write_count", 64'(wr_cnt - base), 64'd5);
        check("t5_last_word", 64'(last_word), 64'(fib_word(s0, s1, 4)));
        check_idle_after("t5");
        // restart with start and abort together: start wins
        s0 = $urandom;
        s1 = $urandom;
        push_seq(s0, s1, NREG);
        abort = 1'b1;
        do_start(s0, s1, k);
        abort = 1'b0;
        wait_done(100);
        check("t5_restart_done_cycle", 64'(last_done_cyc), 64'(k + NREG));
        check_idle_after("t5_restart");
        tick();

        // 6: asynchronous reset at write 10
        s0 = $urandom;
        s1 = $urandom;
        base = wr_cnt;
        d0 = done_cnt;
        push_seq(s0, s1, 10);
        do_start(s0, s1, k);
        wait_writes(base + 10, 100);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_we", 64'(we), 64'd0);
        check("t6_rst_waddr", 64'(waddr), 64'd0);
        check("t6_rst_wdata", 64'(wdata), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_done", 64'(done), 64'd0);
        check("t6_rst_last_word", 64'(last_word), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t6_post_we", 64'(we), 64'd0);
            check("t6_post_done", 64'(done), 64'd0);
        end
        check("t6_no_done", 64'(done_cnt - d0), 64'd0);
        check("t6_write_count", 64'(wr_cnt - base), 64'd10);
        check_idle_after("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
